// File: rtl/oh_ser2par_pkg.sv
// ---------------------------------------------------------------------------
// oh_ser2par_pkg
// Shared definitions for the serial-to-parallel controller and its datapath.
//   state_t           : controller state encoding
//   ST_IDLE/SHIFT/STALL : state encodings
// ---------------------------------------------------------------------------
package oh_ser2par_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;  // waiting for a start-of-frame beat
  localparam state_t ST_SHIFT = 2'd1;  // assembling beats into the shifter
  localparam state_t ST_STALL = 2'd2;  // full word waiting on a busy holding reg

endpackage : oh_ser2par_pkg

// File: rtl/oh_ser2par.sv
// ---------------------------------------------------------------------------
// oh_ser2par
// Datapath: beat shifter plus output holding register.
//   clk, reset  : rising-edge clock, async active-high reset
//   lsbfirst_i  : 1 = first beat lands in the low bits of the word
//   shift_i     : push din_i into the shifter this cycle
//   load_i      : copy the current (pre-shift) shifter value into holding
//   din_i       : serial beat
//   dout_o      : holding register contents
// ---------------------------------------------------------------------------
module oh_ser2par #(
  parameter int PW = 64,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lsbfirst_i,
  input  logic          shift_i,
  input  logic          load_i,
  input  logic [SW-1:0] din_i,
  output logic [PW-1:0] dout_o
);

  logic [PW-1:0] shift_q, shift_d;
  logic [PW-1:0] hold_q;

  // LSB-first: new beats enter at the top and move down, so after N beats the
  // first one sits at [SW-1:0]. MSB-first is the mirror image.
  always_comb begin
    shift_d = lsbfirst_i ? {din_i, shift_q[PW-1:SW]}
                         : {shift_q[PW-SW-1:0], din_i};
  end

  // NOTE: sequential state uses non-blocking assignments so that the holding
  // register captures the pre-shift value when load and shift coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      hold_q  <= '0;
    end else begin
      if (shift_i) shift_q <= shift_d;
      if (load_i)  hold_q  <= shift_q;
    end
  end

  assign dout_o = hold_q;

endmodule : oh_ser2par

// File: rtl/oh_ser2par_ctrl.sv
// ---------------------------------------------------------------------------
// oh_ser2par_ctrl
// Frames serial beats into PW-bit words with a one-entry output holding reg.
//   clk, reset        : rising-edge clock, async active-high reset
//   enable            : controller enable (0 drops any partial frame)
//   lsbfirst          : beat order, static while enabled
//   din/din_valid/din_sof/din_ready : serial input handshake
//   dout/dout_valid/dout_ready      : parallel output handshake
//   frame_err/err_clear             : sticky framing error and its clear
// ---------------------------------------------------------------------------
module oh_ser2par_ctrl
  import oh_ser2par_pkg::*;
#(
  parameter int PW = 64,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          lsbfirst,
  input  logic [SW-1:0] din,
  input  logic          din_valid,
  input  logic          din_sof,
  output logic          din_ready,
  output logic [PW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          frame_err,
  input  logic          err_clear
);

  localparam int            N    = PW / SW;
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load_pend_q, load_pend_d;
  logic          dout_valid_q, dout_valid_d;
  logic          frame_err_q, frame_err_d;

  logic hold_free, load, accept, shift, err_set;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      load_pend_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      load_pend_q  <= load_pend_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Output / handshake logic
  always_comb begin
    hold_free = !dout_valid_q || dout_ready;
    load      = load_pend_q && hold_free;
    // A finished word that cannot move yet blocks new beats in any state, so
    // the shifter stays frozen until the holding register takes it.
    din_ready = !reset && (state_q != ST_STALL) && !(load_pend_q && !hold_free);
    accept    = din_valid && din_ready;
    case (state_q)
      ST_IDLE:  shift = accept && din_sof && enable;
      ST_SHIFT: shift = accept && enable;
      default:  shift = 1'b0;
    endcase
  end

  // Next-state logic
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    load_pend_d = load_pend_q && !load;
    err_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (accept && din_sof && enable) begin
          state_d = ST_SHIFT;
          count_d = ONE;
        end
      end
      ST_SHIFT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (load_pend_q && !hold_free) begin
          state_d = ST_STALL;
        end else if (accept) begin
          if (din_sof && (count_q != '0)) begin
            // Premature start: drop the partial frame, this beat starts anew.
            err_set = 1'b1;
            count_d = ONE;
          end else if (count_q == LAST) begin
            count_d     = '0;
            load_pend_d = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      ST_STALL: begin
        if (!enable) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (dout_ready) begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    // A load alongside a transfer keeps the register occupied with the new word.
    dout_valid_d = load || (dout_valid_q && !dout_ready);
    frame_err_d  = err_set || (frame_err_q && !err_clear);
  end

  oh_ser2par #(
    .PW (PW),
    .SW (SW)
  ) u_dp (
    .clk        (clk),
    .reset      (reset),
    .lsbfirst_i (lsbfirst),
    .shift_i    (shift),
    .load_i     (load),
    .din_i      (din),
    .dout_o     (dout)
  );

  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;

endmodule : oh_ser2par_ctrl

// File: tb/tb_oh_ser2par_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oh_ser2par_ctrl
// Directed bench for oh_ser2par_ctrl at PW=16, SW=8. Expected words are queued
// when frames are sent; a monitor pops and compares on each output transfer.
// ---------------------------------------------------------------------------
module tb_oh_ser2par_ctrl;

  localparam int PW = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, lsbfirst, din_valid, din_sof, dout_ready, err_clear;
  logic [SW-1:0] din;
  logic          din_ready, dout_valid, frame_err;
  logic [PW-1:0] dout;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            t0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] mon_exp;

  oh_ser2par_ctrl #(.PW(PW), .SW(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lsbfirst   (lsbfirst),
    .din        (din),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h expected none", dout);
      end else begin
        mon_exp = sb.pop_front();
        check("dout_word", {48'd0, dout}, {48'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [SW-1:0] d, input logic sof);
    int waited = 0;
    din = d;
    din_sof = sof;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!din_ready) check("beat_accept_timeout", {63'd0, din_ready}, 64'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sof = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; lsbfirst = 1'b1; din = '0;
    din_valid = 1'b0; din_sof = 1'b0; dout_ready = 1'b1; err_clear = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", {63'd0, din_ready}, 64'd0);
    check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    check("rst_dout", {48'd0, dout}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b1;
    tick();
    check("idle_din_ready", {63'd0, din_ready}, 64'd1);

    // LSB-first frame and its latency
    sb.push_back(16'h1234);
    send_beat(8'h34, 1'b1);
    send_beat(8'h12, 1'b0);
    check("latency_not_early", {63'd0, dout_valid}, 64'd0);
    tick();
    check("latency_valid", {63'd0, dout_valid}, 64'd1);
    check("latency_word", {48'd0, dout}, 64'h1234);
    repeat (2) tick();

    // MSB-first, back-to-back frames (third without sof), full throughput
    enable = 1'b0;
    tick();
    lsbfirst = 1'b0;
    enable = 1'b1;
    sb.push_back(16'h1234);
    sb.push_back(16'h5678);
    sb.push_back(16'h9abc);
    t0 = cyc;
    send_beat(8'h12, 1'b1); send_beat(8'h34, 1'b0);
    send_beat(8'h56, 1'b1); send_beat(8'h78, 1'b0);
    send_beat(8'h9a, 1'b0); send_beat(8'hbc, 1'b0);
    check("throughput_cycles", 64'(cyc - t0), 64'd6);
    repeat (3) tick();

    // Back-pressure: second word stalls, then both drain in order
    dout_ready = 1'b0;
    sb.push_back(16'haaaa);
    sb.push_back(16'hbbbb);
    send_beat(8'haa, 1'b1); send_beat(8'haa, 1'b0);
    send_beat(8'hbb, 1'b1); send_beat(8'hbb, 1'b0);
    check("stall_din_ready", {63'd0, din_ready}, 64'd0);
    repeat (3) tick();
    check("stall_din_ready_held", {63'd0, din_ready}, 64'd0);
    check("stall_dout_held", {48'd0, dout}, 64'haaaa);
    check("stall_dout_valid", {63'd0, dout_valid}, 64'd1);
    dout_ready = 1'b1;
    repeat (4) tick();
    check("stall_drained", {63'd0, dout_valid}, 64'd0);

    // Framing error, clear, and set-wins-over-clear
    enable = 1'b0;
    tick();
    lsbfirst = 1'b1;
    enable = 1'b1;
    sb.push_back(16'h3322);
    send_beat(8'h11, 1'b1);
    send_beat(8'h22, 1'b1);
    check("ferr_set", {63'd0, frame_err}, 64'd1);
    send_beat(8'h33, 1'b0);
    tick();
    err_clear = 1'b1;
    tick();
    check("ferr_cleared", {63'd0, frame_err}, 64'd0);
    sb.push_back(16'h6655);
    send_beat(8'h44, 1'b1);
    send_beat(8'h55, 1'b1);
    check("ferr_set_wins", {63'd0, frame_err}, 64'd1);
    send_beat(8'h66, 1'b0);
    check("ferr_clear_after", {63'd0, frame_err}, 64'd0);
    err_clear = 1'b0;
    repeat (3) tick();

    // Reset mid-frame with a word parked in the holding register
    dout_ready = 1'b0;
    send_beat(8'hcd, 1'b1);
    send_beat(8'hef, 1'b0);
    send_beat(8'hab, 1'b1);
    check("held_before_reset", {48'd0, dout}, 64'hefcd);
    reset = 1'b1;
    #1;
    check("mid_rst_din_ready", {63'd0, din_ready}, 64'd0);
    check("mid_rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    check("mid_rst_dout", {48'd0, dout}, 64'd0);
    tick();
    reset = 1'b0;
    dout_ready = 1'b1;
    repeat (2) tick();
    check("post_rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    sb.push_back(16'h5678);
    send_beat(8'h78, 1'b1);
    send_beat(8'h56, 1'b0);
    repeat (3) tick();

    // enable drop discards the partial frame; only the new frame emerges
    sb.push_back(16'h4321);
    send_beat(8'h99, 1'b1);
    enable = 1'b0;
    send_beat(8'h77, 1'b0);
    enable = 1'b1;
    send_beat(8'h88, 1'b0);
    send_beat(8'h21, 1'b1);
    send_beat(8'h43, 1'b0);
    repeat (4) tick();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_oh_ser2par_ctrl

// File: doc/oh_ser2par_ctrl.md
OH_SER2PAR_CTRL -- requirements
Module: oh_ser2par_ctrl

Interface
REQ-001 Parameter PW, 64, parallel word width.
REQ-002 Parameter SW, 8, serial beat width; PW/SW SHALL be an integer N >= 2.
REQ-003 Localparam CW, $clog2(N), beat-counter width.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  controller enable.
REQ-007 lsbfirst  in  1  beat order; SHALL be held static while enable=1.
REQ-008 din  in  SW  serial beat.
REQ-009 din_valid  in  1  beat present.
REQ-010 din_sof  in  1  beat is first of a frame; qualified by din_valid.
REQ-011 din_ready  out  1  beat accepted when din_valid&din_ready.
REQ-012 dout  out  PW  assembled word from holding register.
REQ-013 dout_valid  out  1  holding register occupied.
REQ-014 dout_ready  in  1  downstream takes word when dout_valid&dout_ready.
REQ-015 frame_err  out  1  sticky framing error.
REQ-016 err_clear  in  1  clears frame_err.

Function
REQ-017 States SHALL be IDLE, SHIFT and STALL.
REQ-018 IDLE: din_ready=1; beats without din_sof SHALL be accepted and discarded; accepted din_sof beat with enable=1 SHALL shift, set count=1 and go to SHIFT.
REQ-019 SHIFT: din_ready=1; each accepted beat SHALL pulse shift for exactly that cycle and increment count.
REQ-020 Accepting beat N-1 (count==N-1) SHALL set load_pend, wrap count to 0 and stay in SHIFT.
REQ-021 In the cycle load_pend=1 with holding free (dout_valid=0 or dout_ready=1), the holding register SHALL load the shifter output and dout_valid SHALL be 1 next cycle; a concurrent shift in that cycle is permitted (pre-shift value is loaded).
REQ-022 load_pend=1 with holding not free SHALL move to STALL with din_ready=0 and shift=0; shifter contents SHALL be frozen.
REQ-023 STALL: when dout_ready=1, the holding register SHALL load, load_pend SHALL clear and state SHALL return to SHIFT.
REQ-024 Latency: last beat accepted at edge E -> dout_valid=1 after edge E+1 when holding is free; full throughput of one beat per cycle with dout_ready=1.
REQ-025 dout_valid SHALL clear on a transfer with no simultaneous load; simultaneous transfer and load SHALL keep dout_valid=1 with the new word.
REQ-026 Accepted din_sof in SHIFT with count!=0 SHALL set frame_err, discard the partial frame and restart with count=1.
REQ-027 Accepted din_sof with count==0 in SHIFT SHALL start a normal frame without error.
REQ-028 Accepted non-sof beat at count==0 in SHIFT SHALL continue framing (back-to-back frames without sof).
REQ-029 enable=0 SHALL force IDLE next edge and discard the partial frame; pending load and holding register contents SHALL still complete and drain.
REQ-030 err_clear=1 SHALL clear frame_err unless a new error occurs in the same cycle (set wins).
REQ-031 With lsbfirst=1 the first beat SHALL end at dout[SW-1:0]; with lsbfirst=0 at dout[PW-1:PW-SW].

Reset
REQ-032 On reset: state=IDLE, count=0, load_pend=0, dout_valid=0, dout=0, frame_err=0, shifter=0.
REQ-033 din_ready SHALL be 0 while reset=1.
REQ-034 Reset mid-frame SHALL discard all partial and held data without producing dout_valid.

Structure
REQ-035 State encodings SHALL be localparams in a shared oh_ser2par_pkg package.
REQ-036 The datapath SHALL be one instance of sub-module oh_ser2par (PW, SW passed through; shift driven by controller).

Verification (PW=16, SW=8, N=2)
REQ-037 lsbfirst=1, beats 0x34(sof),0x12 -> dout=0x1234, dout_valid one cycle after second accept.
REQ-038 lsbfirst=0, beats 0x12(sof),0x34 -> dout=0x1234; continuous frames at dout_ready=1 -> no din_ready drop.
REQ-039 dout_ready=0, frames 0xAAAA then 0xBBBB -> din_ready=0 after second frame, dout=0xAAAA held; dout_ready=1 -> 0xAAAA then 0xBBBB, no loss.
REQ-040 Beats 0x11(sof),0x22(sof),0x33 -> frame_err=1, dout=0x3322 (lsbfirst=1); err_clear -> frame_err=0.
REQ-041 Reset asserted after first beat -> dout_valid=0, count=0; next frame 0x5678 assembles correctly.
REQ-042 enable=0 after first beat, then re-enabled with new frame -> only new frame appears on dout.
